// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC and the IF/ID register, issues single-outstanding fetches on a
// req/addr_ok/data_ok bus, applies decode redirects after the delay slot and
// exception flushes with top priority.
// Optional feature macro: IF_ADEL_EN (misaligned-PC fetch address error).
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        do_branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        jump_flag_i,
  input  logic [25:0] jump_index_i,
  input  logic        jr_flag_i,
  input  logic [31:0] jr_addr_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic        id_valid_o,
  output logic        if_adel_o,
  output logic        if_busy_o
);

  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] redir_r;
  logic [31:0] skid_r;
  logic        redir_v;
  logic        cancel_r;

  logic        fetch_blocked;
  logic        addr_acc;
  logic        deliver_mem;
  logic        deliver_skid;
  logic        deliver_adel;
  logic        deliver;
  logic        redir_sample;
  logic [31:0] deliver_instr;
  logic [31:0] pc_plus4;
  logic [31:0] redir_target;
  logic [31:0] next_pc;

`ifdef IF_ADEL_EN
  // Set once the address-error bubble has been handed to decode; fetching stays
  // parked until a flush supplies a new PC.
  logic        adel_idle_r;
  assign fetch_blocked = (pc_r[1:0] != 2'b00) | adel_idle_r;
  assign deliver_adel  = (state_r == FETCH) & (pc_r[1:0] != 2'b00) & ~adel_idle_r
                         & ~if_stall_i & ~flush_i;
  assign inst_addr_o   = pc_r;
`else
  assign fetch_blocked = 1'b0;
  assign deliver_adel  = 1'b0;
  assign inst_addr_o   = {pc_r[31:2], 2'b00};
`endif

  assign inst_req_o   = ~rst_i & (state_r == FETCH) & ~fetch_blocked;
  assign addr_acc     = inst_req_o & inst_addr_ok_i;
  assign deliver_mem  = (state_r == WAIT) & inst_data_ok_i & ~cancel_r & ~if_stall_i & ~flush_i;
  assign deliver_skid = (state_r == HOLD) & ~if_stall_i & ~flush_i;
  assign deliver      = deliver_mem | deliver_skid | deliver_adel;
  assign pc_plus4     = pc_r + 32'd4;
  assign if_busy_o    = (state_r == WAIT) | (state_r == HOLD);

  // A control transfer in decode is only taken when decode actually consumes it.
  assign redir_sample = id_valid_o & ~if_stall_i & (jr_flag_i | jump_flag_i | do_branch_i);

  // Select the instruction word handed to decode (address error delivers a nop).
  always_comb begin
    deliver_instr = 32'b0;
    if (deliver_mem)       deliver_instr = inst_rdata_i;
    else if (deliver_skid) deliver_instr = skid_r;
  end

  // Redirect target (jr > jump > branch) and the PC following the delivered word.
  always_comb begin
    redir_target = branch_addr_i;
    if (jr_flag_i)        redir_target = jr_addr_i;
    else if (jump_flag_i) redir_target = {id_pc4_o[31:28], jump_index_i, 2'b00};
    next_pc = pc_plus4;
    if (redir_sample)     next_pc = redir_target;  // delay slot delivered this cycle
    else if (redir_v)     next_pc = redir_r;
  end

  // PC, pending redirect and fetch FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= FETCH;
      pc_r        <= RESET_PC;
      redir_r     <= 32'b0;
      redir_v     <= 1'b0;
      cancel_r    <= 1'b0;
      skid_r      <= 32'b0;
`ifdef IF_ADEL_EN
      adel_idle_r <= 1'b0;
`endif
    end else if (flush_i) begin
      pc_r        <= flush_pc_i;
      redir_v     <= 1'b0;
`ifdef IF_ADEL_EN
      adel_idle_r <= 1'b0;
`endif
      case (state_r)
        FETCH: if (addr_acc) begin
          state_r  <= WAIT;
          cancel_r <= 1'b1;
        end
        // A response landing with the flush retires the outstanding fetch,
        // so nothing is left to cancel.
        WAIT: if (inst_data_ok_i) begin
          state_r  <= FETCH;
          cancel_r <= 1'b0;
        end else begin
          cancel_r <= 1'b1;
        end
        HOLD:    state_r <= FETCH;
        default: state_r <= FETCH;
      endcase
    end else begin
      if (deliver) begin
        pc_r    <= next_pc;
        redir_v <= 1'b0;
      end else if (redir_sample) begin
        redir_r <= redir_target;
        redir_v <= 1'b1;
      end
`ifdef IF_ADEL_EN
      if (deliver_adel) adel_idle_r <= 1'b1;
`endif
      case (state_r)
        FETCH: if (addr_acc) state_r <= WAIT;
        WAIT: if (inst_data_ok_i) begin
          if (cancel_r) begin
            cancel_r <= 1'b0;
            state_r  <= FETCH;
          end else if (!if_stall_i) begin
            state_r  <= FETCH;
          end else begin
            skid_r   <= inst_rdata_i;
            state_r  <= HOLD;
          end
        end
        HOLD:    if (!if_stall_i) state_r <= FETCH;
        default: state_r <= FETCH;
      endcase
    end
  end

  // IF/ID pipeline register: flush and idle cycles load a bubble, stall holds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_instr_o <= 32'b0;
      id_pc_o    <= 32'b0;
      id_pc4_o   <= 32'd4;
      id_valid_o <= 1'b0;
      if_adel_o  <= 1'b0;
    end else if (flush_i) begin
      id_instr_o <= 32'b0;
      id_pc_o    <= 32'b0;
      id_pc4_o   <= 32'd4;
      id_valid_o <= 1'b0;
      if_adel_o  <= 1'b0;
    end else if (deliver) begin
      id_instr_o <= deliver_instr;
      id_pc_o    <= pc_r;
      id_pc4_o   <= pc_plus4;
      id_valid_o <= 1'b1;
      if_adel_o  <= deliver_adel;
    end else if (!if_stall_i) begin
      id_instr_o <= 32'b0;
      id_pc_o    <= 32'b0;
      id_pc4_o   <= 32'd4;
      id_valid_o <= 1'b0;
      if_adel_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized bench for if_stage. A bus slave with random wait
// states and a decode-side driver (random stalls, branches, flushes) run
// against a reference model of the architectural PC stream.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
`ifdef IF_ADEL_EN
  localparam bit ADEL_EN = 1'b1;
`else
  localparam bit ADEL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_stall_i, flush_i, do_branch_i, jump_flag_i, jr_flag_i;
  logic [31:0] flush_pc_i, branch_addr_i, jr_addr_i;
  logic [25:0] jump_index_i;
  logic        inst_req_o, inst_addr_ok_i, inst_data_ok_i;
  logic [31:0] inst_addr_o, inst_rdata_i;
  logic [31:0] id_instr_o, id_pc_o, id_pc4_o;
  logic        id_valid_o, if_adel_o, if_busy_o;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .rst_i(rst_i), .if_stall_i(if_stall_i), .flush_i(flush_i),
    .flush_pc_i(flush_pc_i), .do_branch_i(do_branch_i), .branch_addr_i(branch_addr_i),
    .jump_flag_i(jump_flag_i), .jump_index_i(jump_index_i), .jr_flag_i(jr_flag_i),
    .jr_addr_i(jr_addr_i), .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i),
    .inst_rdata_i(inst_rdata_i), .id_instr_o(id_instr_o), .id_pc_o(id_pc_o),
    .id_pc4_o(id_pc4_o), .id_valid_o(id_valid_o), .if_adel_o(if_adel_o),
    .if_busy_o(if_busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: next PC decode should see, pending delay-slot target.
  logic [31:0] exp_pc;
  logic        slot_pending;
  logic [31:0] slot_target;
  logic        adel_idle_m;
  // Bus slave state.
  logic        pend;
  logic [31:0] pend_addr;
  // Previous-cycle IF/ID sample for hold checking.
  logic        prev_hold, prev_valid;
  logic [31:0] prev_pc, prev_instr;
  int cyc = 0, first_req_cyc = -1, first_valid_cyc = -1, idle_cnt = 0, n_consumed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h2402_0001;
  endfunction

  task automatic quiet_inputs();
    if_stall_i = 0; flush_i = 0; flush_pc_i = 0; do_branch_i = 0; branch_addr_i = 0;
    jump_flag_i = 0; jump_index_i = 0; jr_flag_i = 0; jr_addr_i = 0;
    inst_addr_ok_i = 0; inst_data_ok_i = 0; inst_rdata_i = 0;
  endtask

  // Assert reset at a negedge, check reset values, release, then send a stray data_ok.
  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    check("rst_req",   {31'b0, inst_req_o}, 32'd0);
    check("rst_valid", {31'b0, id_valid_o}, 32'd0);
    check("rst_instr", id_instr_o, 32'd0);
    check("rst_pc",    id_pc_o, 32'd0);
    check("rst_pc4",   id_pc4_o, 32'd4);
    check("rst_adel",  {31'b0, if_adel_o}, 32'd0);
    check("rst_busy",  {31'b0, if_busy_o}, 32'd0);
    @(negedge clk);
    quiet_inputs();
    rst_i = 1'b0;
    #1;
    check("first_req",  {31'b0, inst_req_o}, 32'd1);
    check("first_addr", inst_addr_o, RESET_PC);
    inst_data_ok_i = 1'b1;
    inst_rdata_i   = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    inst_data_ok_i = 1'b0;
    exp_pc = RESET_PC; slot_pending = 0; slot_target = 0; adel_idle_m = 0;
    pend = 0; pend_addr = 0; prev_hold = 0; idle_cnt = 0;
  endtask

  task automatic run(input int cycles, input int stall_pct, input int wait_pct,
                     input int br_pct, input int fl_pct, input int force_at,
                     input logic [31:0] force_pc);
    for (int i = 0; i < cycles; i++) begin
      logic v, iadel, do_flush, do_stall, adel_exp, give_d, give_a, req_now;
      logic [31:0] ipc, iinstr, ipc4, t, a_now;
      int kind;
      cyc++;
      v = id_valid_o; ipc = id_pc_o; iinstr = id_instr_o; ipc4 = id_pc4_o; iadel = if_adel_o;
      if (prev_hold) begin
        check("hold_pc",    ipc, prev_pc);
        check("hold_instr", iinstr, prev_instr);
        check("hold_valid", {31'b0, v}, {31'b0, prev_valid});
      end
      if (!v) begin
        check("bubble_instr", iinstr, 32'd0);
        check("bubble_pc",    ipc, 32'd0);
        check("bubble_pc4",   ipc4, 32'd4);
        check("bubble_adel",  {31'b0, iadel}, 32'd0);
      end
      if (pend)        check("busy_outstanding", {31'b0, if_busy_o}, 32'd1);
      if (adel_idle_m) check("adel_no_req", {31'b0, inst_req_o}, 32'd0);
      if (v && first_valid_cyc < 0) first_valid_cyc = cyc;

      // Decode-side drive for the coming edge.
      do_flush = (i == force_at) || (int'($urandom_range(99)) < fl_pct);
      do_stall = int'($urandom_range(99)) < stall_pct;
      if_stall_i = do_stall; flush_i = do_flush;
      flush_pc_i = (i == force_at) ? force_pc : ($urandom() & 32'hFFFF_FFFC);
      jr_flag_i = 0; jump_flag_i = 0; do_branch_i = 0;
      jr_addr_i = $urandom() & 32'hFFFF_FFFC;
      branch_addr_i = $urandom() & 32'hFFFF_FFFC;
      jump_index_i = 26'($urandom());
      if (do_flush) begin
        exp_pc = flush_pc_i; slot_pending = 0; adel_idle_m = 0; idle_cnt = 0;
      end else if (v && !do_stall) begin
        adel_exp = ADEL_EN && (exp_pc[1:0] != 2'b00);
        if (adel_idle_m) check("idle_valid", {31'b0, v}, 32'd0);
        check("pc",    ipc, exp_pc);
        check("instr", iinstr, adel_exp ? 32'd0 : mem_word(exp_pc));
        check("pc4",   ipc4, exp_pc + 32'd4);
        check("adel",  {31'b0, iadel}, {31'b0, adel_exp});
        $display("txn pc=%08h instr=%08h adel=%0d", ipc, iinstr, iadel);
        idle_cnt = 0; n_consumed++;
        if (adel_exp) begin
          adel_idle_m = 1; slot_pending = 0;
        end else if (slot_pending) begin
          exp_pc = slot_target; slot_pending = 0;
        end else begin
          if (int'($urandom_range(99)) < br_pct) begin
            kind = int'($urandom_range(2));
            if (kind == 0) begin
              jr_flag_i = 1; jump_flag_i = 1'($urandom()); do_branch_i = 1'($urandom());
              t = jr_addr_i;
            end else if (kind == 1) begin
              jump_flag_i = 1; do_branch_i = 1'($urandom());
              t = exp_pc + 32'd4;
              t = {t[31:28], jump_index_i, 2'b00};
            end else begin
              do_branch_i = 1; t = branch_addr_i;
            end
            slot_pending = 1; slot_target = t;
          end
          exp_pc = exp_pc + 32'd4;
        end
      end else begin
        // Not consumed this cycle: control flags must be ignored.
        jr_flag_i = 1'($urandom()); jump_flag_i = 1'($urandom()); do_branch_i = 1'($urandom());
        if (!adel_idle_m) idle_cnt++;
      end

      // Bus slave drive.
      give_d = pend && (int'($urandom_range(99)) >= wait_pct);
      inst_data_ok_i = give_d;
      inst_rdata_i = give_d ? mem_word(pend_addr) : $urandom();
      req_now = inst_req_o; a_now = inst_addr_o;
      give_a = req_now ? (int'($urandom_range(99)) >= wait_pct) : (int'($urandom_range(99)) < 10);
      inst_addr_ok_i = give_a;
      if (req_now && give_a) begin
        check("req_aligned", {30'b0, a_now[1:0]}, 32'd0);
        if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (idle_cnt > 300) begin
        check("progress", idle_cnt, 32'd0);
        break;
      end
      prev_hold = do_stall && !do_flush; prev_valid = v; prev_pc = ipc; prev_instr = iinstr;
      @(posedge clk);
      if (give_d) pend = 0;
      if (req_now && give_a) begin pend = 1; pend_addr = a_now; end
      @(negedge clk);
    end
  endtask

  initial begin
    quiet_inputs();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();
    // Zero-wait, no stall: sequential stream and minimum latency.
    run(8, 0, 0, 0, 0, -1, 32'd0);
    check("latency", 32'(first_valid_cyc - first_req_cyc), 32'd2);
    run(1500, 30, 30, 25, 3, -1, 32'd0);
    // PC wrap-around.
    run(40, 20, 20, 0, 0, 0, 32'hFFFF_FFF8);
    // Flush into the exception vector with a busy bus.
    run(60, 30, 40, 20, 0, 5, 32'hBFC0_0380);
    // Reset in the middle of traffic.
    do_reset();
    run(800, 40, 20, 30, 2, -1, 32'd0);
`ifdef IF_ADEL_EN
    run(30, 0, 0, 0, 0, 0, 32'hBFC0_0382);
    run(60, 20, 20, 20, 0, 0, 32'hBFC0_0400);
`endif
    check("consumed_enough", {31'b0, n_consumed > 200}, 32'd1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
